instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_pc.sv | 49 ++++
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM state encoding, reset PC default, NOP word and the
//               opcode/funct field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM states (2-bit explicit encoding)
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        DMA   = 2'd2
    } fetch_state_t;

    // Default PC after reset (word aligned)
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

    // Instruction register contents when no instruction has been latched
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    // Instruction field bit positions
    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 26;
    localparam int c_FUNCT_MSB  = 5;
    localparam int c_FUNCT_LSB  = 0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register. Redirect (word-aligned by masking
//               the two low bits) has priority over the sequential +4
//               increment. Arithmetic wraps modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_inc_en,
    input  logic              i_redirect_en,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_seq
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_redirect_aligned;

    // Sequential successor and aligned redirect target
    always_comb begin
        w_pc_seq           = r_pc + ADDR_W'(4);
        w_redirect_aligned = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end

    // PC update: reset, then redirect, then increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
        end else if (i_redirect_en) begin
            r_pc <= w_redirect_aligned;
        end else if (i_inc_en) begin
            r_pc <= w_pc_seq;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_seq = w_pc_seq;

endmodule : fetch_pc
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues word reads over a req/ack
//               handshake, latches the instruction register, presents
//               Opcode/FUNCT with a valid flag, accepts PC redirects and
//               yields the instruction bus to DMA between fetches.
//               Build option: define FETCH_DMA_EN to enable the DMA
//               hold/hold-acknowledge arbitration; otherwise dma_hold is
//               ignored and dma_hlda stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        FUNCT,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dma_hold,
    output logic              dma_hlda
);

    fetch_state_t      r_state;
    logic              r_imem_req;
    logic              r_squash;
    logic [ADDR_W-1:0] r_hold_addr;
    logic              r_ir_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic              r_dma_hlda;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_seq;
    logic              w_pc_inc;
    logic              w_dma_hold;

`ifdef FETCH_DMA_EN
    assign w_dma_hold = dma_hold;
`else
    // DMA arbitration compiled out: the hold request is never honoured
    logic w_unused_dma_hold;
    assign w_unused_dma_hold = dma_hold;
    assign w_dma_hold        = 1'b0;
`endif

    // PC advances only when a non-squashed fetch is accepted
    assign w_pc_inc = (r_state == FETCH) && r_imem_req && imem_ack && !r_squash;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_inc_en      (w_pc_inc),
        .i_redirect_en (redirect_en),
        .i_redirect_pc (redirect_pc),
        .o_pc          (w_pc),
        .o_pc_seq      (w_pc_seq)
    );

    // Fetch FSM with registered handshake, IR and bus-grant outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= FETCH;
            r_imem_req  <= 1'b0;
            r_squash    <= 1'b0;
            r_hold_addr <= '0;
            r_ir_valid  <= 1'b0;
            r_instr     <= c_NOP_INSTR;
            r_pc_plus4  <= '0;
            r_dma_hlda  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!r_imem_req) begin
                        // First cycle out of reset: open the request
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        if (r_squash || redirect_en) begin
                            // Stale data: drop it and re-request at the new PC
                            r_squash <= 1'b0;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_pc_plus4 <= w_pc_seq;
                            r_ir_valid <= 1'b1;
                            r_imem_req <= 1'b0;
                            r_state    <= ISSUE;
                        end
                    end else if (redirect_en && !r_squash) begin
                        // Request cannot be withdrawn: freeze its address
                        r_squash    <= 1'b1;
                        r_hold_addr <= w_pc;
                    end
                end
                ISSUE: begin
                    if (ir_ready || redirect_en) begin
                        r_ir_valid <= 1'b0;
                        if (w_dma_hold) begin
                            r_dma_hlda <= 1'b1;
                            r_state    <= DMA;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                end
`ifdef FETCH_DMA_EN
                DMA: begin
                    if (!dma_hold) begin
                        r_dma_hlda <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
`endif
                default: begin
                    r_dma_hlda <= 1'b0;
                    r_imem_req <= 1'b0;
                    r_state    <= FETCH;
                end
            endcase
        end
    end

    // While squashing, the outstanding request keeps its original address
    assign imem_addr = r_squash ? r_hold_addr : w_pc;
    assign imem_req  = r_imem_req;
    assign ir_valid  = r_ir_valid;
    assign instr     = r_instr;
    assign Opcode    = r_instr[c_OPCODE_MSB:c_OPCODE_LSB];
    assign FUNCT     = r_instr[c_FUNCT_MSB:c_FUNCT_LSB];
    assign pc_plus4  = r_pc_plus4;
    assign dma_hlda  = r_dma_hlda;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch: reset, basic
//               zero-wait fetch, wait states with IR stall, redirect squash,
//               redirect in ISSUE, DMA arbitration, PC wrap, reset mid-ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] instr;
    logic [5:0]  Opcode;
    logic [5:0]  FUNCT;
    logic [31:0] pc_plus4;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        dma_hold;
    logic        dma_hlda;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .instr       (instr),
        .Opcode      (Opcode),
        .FUNCT       (FUNCT),
        .pc_plus4    (pc_plus4),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dma_hold    (dma_hold),
        .dma_hlda    (dma_hlda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = '0; dma_hold = 1'b0;
        step(); step();
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
        n_total++; if (ir_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ir_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h0) $display("FAIL reset_pc_plus4: got %h expected 0", pc_plus4); else n_pass++;
        n_total++; if (dma_hlda !== 1'b0) $display("FAIL reset_hlda: got %b expected 0", dma_hlda); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", imem_addr); else n_pass++;
    endtask

    task automatic test_basic();
        reset_n = 1'b1;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL basic_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; ir_ready = 1'b1;
        step();
        imem_ack = 1'b0;
        n_total++; if (ir_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL basic_valid: got valid=%b req=%b expected valid=1 req=0", ir_valid, imem_req); else n_pass++;
        n_total++; if (Opcode !== 6'h08) $display("FAIL basic_opcode: got %h expected 08", Opcode); else n_pass++;
        n_total++; if (FUNCT !== 6'h05) $display("FAIL basic_funct: got %h expected 05", FUNCT); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h4) $display("FAIL basic_pc_plus4: got %h expected 4", pc_plus4); else n_pass++;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ir_valid !== 1'b0) $display("FAIL basic_next: got req=%b addr=%h valid=%b expected req=1 addr=4 valid=0", imem_req, imem_addr, ir_valid); else n_pass++;
    endtask

    task automatic test_wait_states();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ir_valid !== 1'b0) $display("FAIL wait_addr_%0d: got req=%b addr=%h valid=%b expected req=1 addr=4 valid=0", i, imem_req, imem_addr, ir_valid); else n_pass++;
        end
        imem_ack = 1'b1; imem_rdata = 32'h8C09_0008;
        step();
        imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        n_total++; if (ir_valid !== 1'b1 || instr !== 32'h8C09_0008 || Opcode !== 6'h23) $display("FAIL wait_latch: got valid=%b instr=%h op=%h expected valid=1 instr=8c090008 op=23", ir_valid, instr, Opcode); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++; if (ir_valid !== 1'b1 || instr !== 32'h8C09_0008 || imem_req !== 1'b0) $display("FAIL wait_stall_%0d: got valid=%b instr=%h req=%b expected valid=1 instr=8c090008 req=0", i, ir_valid, instr, imem_req); else n_pass++;
        end
        n_total++; if (pc_plus4 !== 32'h8) $display("FAIL wait_pc_plus4: got %h expected 8", pc_plus4); else n_pass++;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        n_total++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL wait_consume: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=8", ir_valid, imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_en = 1'b0;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL squash_hold0: got req=%b addr=%h expected req=1 addr=8", imem_req, imem_addr); else n_pass++;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL squash_hold1: got req=%b addr=%h expected req=1 addr=8", imem_req, imem_addr); else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        n_total++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || instr !== 32'h8C09_0008) $display("FAIL squash_drop: got valid=%b req=%b addr=%h instr=%h expected valid=0 req=1 addr=100 instr=8c090008", ir_valid, imem_req, imem_addr, instr); else n_pass++;
        imem_rdata = 32'h0000_0020;
        step();
        imem_ack = 1'b0;
        n_total++; if (ir_valid !== 1'b1 || FUNCT !== 6'h20 || pc_plus4 !== 32'h104) $display("FAIL redirect_fetch: got valid=%b funct=%h pc_plus4=%h expected valid=1 funct=20 pc_plus4=104", ir_valid, FUNCT, pc_plus4); else n_pass++;
        redirect_en = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_en = 1'b0;
        n_total++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL redirect_issue: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=200", ir_valid, imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_dma();
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222; dma_hold = 1'b1;
        step();
        imem_ack = 1'b0;
        n_total++; if (ir_valid !== 1'b1 || dma_hlda !== 1'b0) $display("FAIL dma_issue: got valid=%b hlda=%b expected valid=1 hlda=0", ir_valid, dma_hlda); else n_pass++;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
`ifdef FETCH_DMA_EN
        n_total++; if (dma_hlda !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0) $display("FAIL dma_grant: got hlda=%b req=%b valid=%b expected hlda=1 req=0 valid=0", dma_hlda, imem_req, ir_valid); else n_pass++;
        step();
        n_total++; if (dma_hlda !== 1'b1 || imem_req !== 1'b0) $display("FAIL dma_hold: got hlda=%b req=%b expected hlda=1 req=0", dma_hlda, imem_req); else n_pass++;
        dma_hold = 1'b0;
        step();
`else
        dma_hold = 1'b0;
`endif
        n_total++; if (dma_hlda !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h204) $display("FAIL dma_release: got hlda=%b req=%b addr=%h expected hlda=0 req=1 addr=204", dma_hlda, imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA; redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_en = 1'b0;
        n_total++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_redirect: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=fffffffc", ir_valid, imem_req, imem_addr); else n_pass++;
        imem_rdata = 32'h0800_0000; ir_ready = 1'b1;
        step();
        imem_ack = 1'b0;
        n_total++; if (ir_valid !== 1'b1 || pc_plus4 !== 32'h0 || Opcode !== 6'h02) $display("FAIL wrap_plus4: got valid=%b pc_plus4=%h op=%h expected valid=1 pc_plus4=0 op=02", ir_valid, pc_plus4, Opcode); else n_pass++;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL rstmid_pre: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); else n_pass++;
        reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        n_total++; if (ir_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_plus4 !== 32'h0) $display("FAIL rstmid: got valid=%b instr=%h req=%b addr=%h pc_plus4=%h expected all 0", ir_valid, instr, imem_req, imem_addr, pc_plus4); else n_pass++;
        reset_n = 1'b1;
        step();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rstmid_restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_redirect();
        test_dma();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
